// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, op and state encodings.
package mdu_pkg;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   // Signed ops work on magnitudes and fix the sign at the end
   function automatic logic is_signed_op(op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
//   start, op, A, B, MTHI, MTLO  : master -> slave
//   busy, done, HI, LO, div_by_zero : slave -> master
interface mdu_if;
   import mdu_pkg::*;

   logic             start;
   op_e              op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             MTHI;
   logic             MTLO;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             div_by_zero;

   modport master (
      output start, op, A, B, MTHI, MTLO,
      input  busy, done, HI, LO, div_by_zero
   );

   modport slave (
      input  start, op, A, B, MTHI, MTLO,
      output busy, done, HI, LO, div_by_zero
   );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// One radix-2 step per cycle (shift-add multiply, restoring divide) sharing a
// 64-bit accumulator and a 33-bit adder/subtractor; sign fix-up in a final cycle.
// Ports: clk, rst_n (async active-low), bus (mdu_if.slave: start/op/A/B/MTHI/MTLO in,
//        busy/done/HI/LO/div_by_zero out).
// Optional: MDU_DIV0_FLAG_EN enables the registered div_by_zero flag; otherwise it is 0.
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   mdu_if.slave bus
);

   localparam int unsigned AW   = 2 * WIDTH;
   localparam int unsigned SW   = WIDTH + 1;
   localparam int unsigned SUMW = WIDTH + 2;

   state_e           state_q, state_nxt;
   logic [CNT_W-1:0] count_q;
   logic [AW-1:0]    acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             is_div_q, neg_res_q, neg_rem_q, b_zero_q;
   logic             busy_q, done_q;

   logic             accept_c, iter_c, fix_c, mv_hi_c, mv_lo_c;
   logic             a_neg_c, b_neg_c;
   logic [WIDTH-1:0] abs_a_c, abs_b_c;
   logic [SW-1:0]    add_a_c, add_b_c;
   logic [SUMW-1:0]  sum_c;
   logic [AW-1:0]    step_c, prod_c;
   logic [WIDTH-1:0] quo_c, rem_c, res_hi_c, res_lo_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   // Next state and control strobes
   always_comb begin
      state_nxt = state_q;
      accept_c  = 1'b0;
      iter_c    = 1'b0;
      fix_c     = 1'b0;
      mv_hi_c   = 1'b0;
      mv_lo_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept_c  = 1'b1;
               state_nxt = S_CALC;
            end else begin
               mv_hi_c = bus.MTHI;
               mv_lo_c = bus.MTLO;
            end
         end
         S_CALC: begin
            iter_c = 1'b1;
            if (count_q == '0) state_nxt = S_FIX;
         end
         S_FIX: begin
            fix_c     = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand magnitudes at accept time
   assign a_neg_c = is_signed_op(bus.op) & bus.A[WIDTH-1];
   assign b_neg_c = is_signed_op(bus.op) & bus.B[WIDTH-1];
   assign abs_a_c = a_neg_c ? WIDTH'(-bus.A) : bus.A;
   assign abs_b_c = b_neg_c ? WIDTH'(-bus.B) : bus.B;

   // Shared adder: add multiplicand (multiply) or subtract divisor (divide);
   // for subtraction the top carry is the "no borrow" indication.
   assign add_a_c = is_div_q ? acc_q[AW-1:WIDTH-1] : {1'b0, acc_q[AW-1:WIDTH]};
   assign add_b_c = is_div_q ? ~{1'b0, mcand_q} : {1'b0, mcand_q};
   assign sum_c   = {1'b0, add_a_c} + {1'b0, add_b_c} + SUMW'(is_div_q);

   // One radix-2 iteration on the accumulator
   always_comb begin
      step_c = acc_q;
      if (is_div_q) begin
         if (sum_c[SW]) step_c = {sum_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else           step_c = {acc_q[AW-2:0], 1'b0};
      end else begin
         if (acc_q[0]) step_c = {sum_c[SW-1:0], acc_q[WIDTH-1:1]};
         else          step_c = {1'b0, acc_q[AW-1:1]};
      end
   end

   // Sign correction; divide by zero forces an all-ones quotient
   always_comb begin
      prod_c = neg_res_q ? AW'(-acc_q) : acc_q;
      quo_c  = neg_res_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_c  = neg_rem_q ? WIDTH'(-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
      if (is_div_q) begin
         res_hi_c = rem_c;
         res_lo_c = b_zero_q ? '1 : quo_c;
      end else begin
         res_hi_c = prod_c[AW-1:WIDTH];
         res_lo_c = prod_c[WIDTH-1:0];
      end
   end

   // Datapath and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         busy_q <= (state_nxt != S_IDLE);
         done_q <= fix_c;
         if (accept_c) begin
            count_q   <= CNT_W'(ITER_COUNT - 1);
            is_div_q  <= bus.op[1];
            neg_res_q <= a_neg_c ^ b_neg_c;
            neg_rem_q <= a_neg_c;
            b_zero_q  <= (bus.B == '0);
            // Divide: dividend in the low half; multiply: multiplier in the low half
            acc_q     <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a_c} : {{WIDTH{1'b0}}, abs_b_c};
            mcand_q   <= bus.op[1] ? abs_b_c : abs_a_c;
         end
         if (iter_c) begin
            acc_q <= step_c;
            if (count_q != '0) count_q <= count_q - CNT_W'(1);
         end
         if (fix_c) begin
            hi_q <= res_hi_c;
            lo_q <= res_lo_c;
         end
         if (mv_hi_c) hi_q <= bus.A;
         if (mv_lo_c) lo_q <= bus.A;
      end
   end

`ifdef MDU_DIV0_FLAG_EN
   logic dz_q;

   // Sticky until the next accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        dz_q <= 1'b0;
      else if (accept_c) dz_q <= 1'b0;
      else if (fix_c)    dz_q <= is_div_q & b_zero_q;
   end

   assign bus.div_by_zero = dz_q;
`else
   assign bus.div_by_zero = 1'b0;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mdu_if bus();

   mult_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef MDU_DIV0_FLAG_EN
   localparam logic DZ_EN = 1'b1;
`else
   localparam logic DZ_EN = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_hi = 32'h0;
   logic [31:0] model_lo = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with empty scoreboard expected none");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, bus.HI, e.hi);
            chk({e.name, "_lo"}, bus.LO, e.lo);
            chk({e.name, "_dz"}, 32'(bus.div_by_zero), 32'(e.dz));
         end
      end
   end

   // Issue one op from just after a negedge and follow it to done (or abort it)
   task automatic run_op(input string name, input op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz, input bit with_mthi, input int disturb_at,
                         input int abort_at);
      exp_t e;
      int   lat = 0;
      int   nb  = 0;
      if (abort_at == 0) begin
         e = '{name, hi, lo, dz};
         sb.push_back(e);
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.MTHI  = with_mthi;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.start = 1'b0;
            bus.MTHI  = 1'b0;
            bus.A     = $urandom;
            bus.B     = $urandom;
            chk({name, "_dz_clr"}, 32'(bus.div_by_zero), 32'h0);
         end
         if (bus.busy === 1'b1) nb++;
         if (n == 20) chk({name, "_hi_hold"}, bus.HI, model_hi);
         if (abort_at > 0 && n == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk({name, "_abort_busy"}, 32'(bus.busy), 32'h0);
            chk({name, "_abort_hi"}, bus.HI, 32'h0);
            chk({name, "_abort_lo"}, bus.LO, 32'h0);
            model_hi = 32'h0;
            model_lo = 32'h0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (disturb_at > 0 && n == disturb_at) begin
            bus.start = 1'b1;
            bus.op    = OP_DIVU;
            bus.A     = 32'hDEAD;
            bus.MTHI  = 1'b1;
            bus.MTLO  = 1'b1;
         end
         if (disturb_at > 0 && n == disturb_at + 1) begin
            bus.start = 1'b0;
            bus.MTHI  = 1'b0;
            bus.MTLO  = 1'b0;
         end
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      chk({name, "_lat"}, 32'(lat), 32'd34);
      chk({name, "_busy_cycles"}, 32'(nb), 32'd33);
      model_hi = hi;
      model_lo = lo;
   endtask

   // MTHI/MTLO move while idle
   task automatic move(input bit to_hi, input logic [31:0] v);
      bus.A    = v;
      bus.MTHI = to_hi;
      bus.MTLO = !to_hi;
      @(negedge clk);
      bus.MTHI = 1'b0;
      bus.MTLO = 1'b0;
      if (to_hi) model_hi = v;
      else       model_lo = v;
      chk(to_hi ? "mthi_hi" : "mtlo_hi", bus.HI, model_hi);
      chk(to_hi ? "mthi_lo" : "mtlo_lo", bus.LO, model_lo);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.A     = '0;
      bus.B     = '0;
      bus.MTHI  = 1'b0;
      bus.MTLO  = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_hi",   bus.HI, 32'h0);
      chk("rst_lo",   bus.LO, 32'h0);
      chk("rst_dz",   32'(bus.div_by_zero), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back chain: each start lands in the previous done cycle
      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0, 0);
      run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0, 0);
      run_op("divu",      OP_DIVU,  32'd20,       32'd10,       32'h00000000, 32'h00000002, 1'b0, 0, 0, 0);
      run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0, 0);
      run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0, 0);
      run_op("divu_z",    OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DZ_EN, 0, 0, 0);
      run_op("div_z",     OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DZ_EN, 0, 0, 0);
      run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0, 0, 0);
      run_op("mult_m1",   OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0, 0, 0, 0);
      run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0, 0, 0);
      @(negedge clk);

      move(1'b1, 32'h00001234);
      move(1'b0, 32'h0000ABCD);

      // start wins over a simultaneous MTHI; mid-op start/MTHI/MTLO ignored
      run_op("start_mthi", OP_MULTU, 32'd3,       32'd4,        32'h00000000, 32'h0000000C, 1'b0, 1, 0, 0);
      run_op("disturb",    OP_MULTU, 32'h10000,   32'h10000,    32'h00000001, 32'h00000000, 1'b0, 0, 10, 0);
      repeat (3) @(negedge clk);
      chk("disturb_idle", 32'(bus.busy), 32'h0);

      run_op("divu_z2",   OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DZ_EN, 0, 0, 0);
      run_op("abort",     OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0,        32'h0,        1'b0, 0, 0, 10);
      run_op("post_rst",  OP_MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 0, 0, 0);

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
